// File: rtl/fft_loader.sv
// Input-side loader for the FFT core: packs streamed complex samples into SRAM words,
// then hands the SRAM to the core and holds o_working until the core reports completion.
module fft_loader #(
    parameter int unsigned SAMPLE_W = 32,
    parameter int unsigned LANES    = 4,
    parameter int unsigned ADDR_W   = 8
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      i_start,
    input  logic [2:0]                i_point_config,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [SAMPLE_W-1:0]       s_data,
    output logic [ADDR_W-1:0]         o_waddress,
    output logic [LANES*SAMPLE_W-1:0] o_wdata,
    output logic                      o_write_enable,
    output logic                      o_sram_sel,
    output logic                      o_working,
    output logic [2:0]                o_point_config,
    input  logic                      i_fft_done,
    output logic                      o_busy,
    output logic                      o_done
);

    localparam int unsigned LaneW     = $clog2(LANES);
    localparam int unsigned WordW     = LANES * SAMPLE_W;
    // Smallest frame (16 points) expressed in words.
    localparam int unsigned WordsBase = 16 / LANES;

    typedef enum logic [1:0] {StIdle, StLoad, StFlush, StRun} state_e;

    state_e              state_q, state_d;
    logic [LaneW-1:0]    lane_cnt_q, lane_cnt_d;
    logic [ADDR_W-1:0]   word_cnt_q, word_cnt_d;
    logic [WordW-1:0]    pack_q, pack_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [WordW-1:0]    wdata_q, wdata_d;
    logic                we_q, we_d;
    logic                sram_sel_q, sram_sel_d;
    logic                working_q, working_d;
    logic                done_q, done_d;
    logic [2:0]          cfg_q, cfg_d;

    logic                xfer;
    logic [2:0]          cfg_clamped;
    logic [ADDR_W:0]     frame_words;
    logic [ADDR_W-1:0]   last_addr;

    assign s_ready     = (state_q == StLoad);
    assign xfer        = s_valid && s_ready;
    assign cfg_clamped = (i_point_config == 3'd7) ? 3'd6 : i_point_config;
    assign frame_words = (ADDR_W+1)'(WordsBase) << cfg_q;
    assign last_addr   = ADDR_W'(frame_words - 1'b1);

    always_comb begin
        state_d    = state_q;
        lane_cnt_d = lane_cnt_q;
        word_cnt_d = word_cnt_q;
        pack_d     = pack_q;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        we_d       = 1'b0;
        sram_sel_d = sram_sel_q;
        working_d  = working_q;
        done_d     = 1'b0;
        cfg_d      = cfg_q;

        unique case (state_q)
            StIdle: begin
                // A start arriving alongside the done pulse belongs to the old frame.
                if (i_start && !done_q) begin
                    cfg_d      = cfg_clamped;
                    lane_cnt_d = '0;
                    word_cnt_d = '0;
                    pack_d     = '0;
                    sram_sel_d = 1'b1;
                    state_d    = StLoad;
                end
            end
            StLoad: begin
                if (xfer) begin
                    pack_d[lane_cnt_q*SAMPLE_W +: SAMPLE_W] = s_data;
                    lane_cnt_d = lane_cnt_q + 1'b1;
                    if (lane_cnt_q == LaneW'(LANES-1)) begin
                        wdata_d    = pack_d;
                        waddr_d    = word_cnt_q;
                        we_d       = 1'b1;
                        word_cnt_d = word_cnt_q + 1'b1;
                        if (word_cnt_q == last_addr) begin
                            state_d = StFlush;
                        end
                    end
                end
            end
            StFlush: begin
                sram_sel_d = 1'b0;
                working_d  = 1'b1;
                state_d    = StRun;
            end
            StRun: begin
                if (i_fft_done) begin
                    working_d = 1'b0;
                    done_d    = 1'b1;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= StIdle;
            lane_cnt_q <= '0;
            word_cnt_q <= '0;
            pack_q     <= '0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            sram_sel_q <= 1'b0;
            working_q  <= 1'b0;
            done_q     <= 1'b0;
            cfg_q      <= '0;
        end else begin
            state_q    <= state_d;
            lane_cnt_q <= lane_cnt_d;
            word_cnt_q <= word_cnt_d;
            pack_q     <= pack_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            sram_sel_q <= sram_sel_d;
            working_q  <= working_d;
            done_q     <= done_d;
            cfg_q      <= cfg_d;
        end
    end

    assign o_waddress     = waddr_q;
    assign o_wdata        = wdata_q;
    assign o_write_enable = we_q;
    assign o_sram_sel     = sram_sel_q;
    assign o_working      = working_q;
    assign o_point_config = cfg_q;
    assign o_busy         = (state_q != StIdle);
    assign o_done         = done_q;

endmodule

// File: tb/tb_fft_loader.sv
// Directed bench for fft_loader: frame loads of several sizes, bubbles, ignored controls,
// run handshake and mid-frame reset, with expected values computed here.
module tb_fft_loader;

    logic         clk = 1'b0;
    logic         rstn;
    logic         i_start;
    logic [2:0]   i_point_config;
    logic         s_valid;
    logic         s_ready;
    logic [31:0]  s_data;
    logic [7:0]   o_waddress;
    logic [127:0] o_wdata;
    logic         o_write_enable;
    logic         o_sram_sel;
    logic         o_working;
    logic [2:0]   o_point_config;
    logic         i_fft_done;
    logic         o_busy;
    logic         o_done;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]   wr_addr_q[$];
    logic [127:0] wr_data_q[$];
    int           bad_sel_writes = 0;

    always #5 clk = ~clk;

    fft_loader dut (
        .clk            (clk),
        .rstn           (rstn),
        .i_start        (i_start),
        .i_point_config (i_point_config),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_data         (s_data),
        .o_waddress     (o_waddress),
        .o_wdata        (o_wdata),
        .o_write_enable (o_write_enable),
        .o_sram_sel     (o_sram_sel),
        .o_working      (o_working),
        .o_point_config (o_point_config),
        .i_fft_done     (i_fft_done),
        .o_busy         (o_busy),
        .o_done         (o_done)
    );

    // Capture write strobes mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (o_write_enable) begin
            wr_addr_q.push_back(o_waddress);
            wr_data_q.push_back(o_wdata);
            if (!o_sram_sel) bad_sel_writes++;
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_frame(input logic [2:0] cfg, input int n_samples, input bit bubbles,
                              input int inject_at);
        bit ready_ok;
        logic [2:0] exp_cfg;
        ready_ok = 1'b1;
        exp_cfg  = (cfg == 3'd7) ? 3'd6 : cfg;
        wr_addr_q.delete();
        wr_data_q.delete();
        i_point_config = cfg;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        check("busy_after_start", o_busy, 1);
        check("sram_sel_after_start", o_sram_sel, 1);
        check("cfg_latched", o_point_config, exp_cfg);
        for (int n = 0; n < n_samples; n++) begin
            if (bubbles) begin
                s_valid = 1'b0;
                if (!s_ready) ready_ok = 1'b0;
                tick();
            end
            s_valid = 1'b1;
            s_data  = n;
            i_start = (n == inject_at);
            if (n == inject_at) i_point_config = 3'd5;
            if (!s_ready) ready_ok = 1'b0;
            tick();
        end
        s_valid = 1'b0;
        i_start = 1'b0;
        check("s_ready_during_load", ready_ok, 1);
        // Flush cycle: last strobe out, SRAM still owned by the loader.
        check("flush_s_ready", s_ready, 0);
        check("flush_working", o_working, 0);
        check("flush_we", o_write_enable, 1);
        check("flush_waddr", o_waddress, (n_samples / 4) - 1);
        tick();
        check("run_working", o_working, 1);
        check("run_sram_sel", o_sram_sel, 0);
        check("run_we", o_write_enable, 0);
        check("run_busy", o_busy, 1);
        check("run_cfg", o_point_config, exp_cfg);
    endtask

    task automatic verify_writes(input int n_words);
        logic [127:0] exp;
        int n;
        check("write_count", wr_addr_q.size(), n_words);
        check("write_without_sel", bad_sel_writes, 0);
        n = (wr_addr_q.size() < n_words) ? wr_addr_q.size() : n_words;
        for (int k = 0; k < n; k++) begin
            for (int j = 0; j < 4; j++) exp[32*j +: 32] = 4 * k + j;
            check("waddr", wr_addr_q[k], k);
            check("wdata", wr_data_q[k], exp);
        end
    endtask

    task automatic run_phase(input int hold);
        bit work_ok;
        work_ok = 1'b1;
        i_fft_done = 1'b0;
        for (int c = 0; c < hold; c++) begin
            if (!o_working) work_ok = 1'b0;
            tick();
        end
        check("working_held", work_ok, 1);
        check("working_before_done", o_working, 1);
        i_fft_done = 1'b1;
        tick();
        i_fft_done = 1'b0;
        check("done_working_low", o_working, 0);
        check("done_pulse", o_done, 1);
        check("done_busy", o_busy, 0);
        // Start coincident with the done pulse must not launch a frame.
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        check("done_one_cycle", o_done, 0);
        check("start_with_done_ignored", o_busy, 0);
        check("idle_sram_sel", o_sram_sel, 0);
    endtask

    initial begin
        rstn = 1'b0;
        i_start = 1'b0;
        i_point_config = 3'd0;
        s_valid = 1'b0;
        s_data = '0;
        i_fft_done = 1'b0;
        #12;
        check("rst_s_ready", s_ready, 0);
        check("rst_busy", o_busy, 0);
        check("rst_we", o_write_enable, 0);
        check("rst_sram_sel", o_sram_sel, 0);
        check("rst_working", o_working, 0);
        check("rst_done", o_done, 0);
        check("rst_cfg", o_point_config, 0);
        check("rst_wdata", o_wdata, 0);
        rstn = 1'b1;
        tick();

        // Basic load with immediate done on the first run cycle.
        load_frame(3'd0, 16, 1'b0, -1);
        verify_writes(4);
        if (wr_data_q.size() > 1)
            check("basic_word1", wr_data_q[1], 128'h00000007_00000006_00000005_00000004);
        run_phase(0);

        // Bubbles on s_valid.
        load_frame(3'd0, 16, 1'b1, -1);
        verify_writes(4);
        run_phase(50);

        // Ignored start and config change mid-load.
        load_frame(3'd0, 16, 1'b0, 5);
        verify_writes(4);
        check("cfg_unchanged", o_point_config, 0);
        run_phase(2);

        // Largest frames.
        load_frame(3'd6, 1024, 1'b0, -1);
        verify_writes(256);
        run_phase(1);
        load_frame(3'd7, 1024, 1'b0, -1);
        verify_writes(256);
        run_phase(1);

        // Reset after 6 of 16 samples.
        i_point_config = 3'd0;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        for (int n = 0; n < 6; n++) begin
            s_valid = 1'b1;
            s_data  = n;
            tick();
        end
        s_valid = 1'b0;
        #2 rstn = 1'b0;
        #1;
        check("mid_rst_s_ready", s_ready, 0);
        check("mid_rst_busy", o_busy, 0);
        check("mid_rst_sram_sel", o_sram_sel, 0);
        check("mid_rst_waddr", o_waddress, 0);
        check("mid_rst_wdata", o_wdata, 0);
        check("mid_rst_we", o_write_enable, 0);
        check("mid_rst_working", o_working, 0);
        check("mid_rst_done", o_done, 0);
        tick();
        rstn = 1'b1;
        tick();
        check("post_rst_idle", o_busy, 0);
        load_frame(3'd0, 16, 1'b0, -1);
        verify_writes(4);
        run_phase(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fft_loader.md
Name: fft_loader

Overview:
- Input-side controller directly upstream of the FFT core.
- Accepts a stream of complex samples over a valid/ready handshake and packs them four-per-word into 128-bit SRAM words at natural-order addresses.
- Once the frame configured by i_point_config is stored, it starts the FFT by driving o_working.
- It then holds o_working until the core reports i_fft_done, and signals frame completion to the system.

Parameters:
- SAMPLE_W, 32, width of one complex sample (real in upper half, imaginary in lower half).
- LANES, 4, samples per SRAM word (LANES*SAMPLE_W = 128).
- ADDR_W, 8, SRAM word address width.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rstn  input  1  asynchronous active-low reset.
- i_start  input  1  single-cycle request to load and process one frame; honoured only in IDLE.
- i_point_config  input  3  frame size select, N = 16 << cfg (cfg 0..6 gives 16..1024 points); cfg 7 is treated as 6.
- s_valid  input  1  upstream sample valid.
- s_ready  output  1  loader can accept a sample.
- s_data  input  32  sample; [31:16] real, [15:0] imaginary, two's complement.
- o_waddress  output  8  SRAM write word address.
- o_wdata  output  128  SRAM write data; sample 4k+j occupies bits [32j+31:32j].
- o_write_enable  output  1  SRAM write strobe, one cycle per word.
- o_sram_sel  output  1  1 = loader owns the SRAM write port, 0 = FFT core owns it.
- o_working  output  1  drives FFT core i_working.
- o_point_config  output  3  latched configuration forwarded to the FFT core, stable for the whole frame.
- i_fft_done  input  1  FFT core completion.
- o_busy  output  1  high in every state except IDLE.
- o_done  output  1  single-cycle pulse when the frame completes.

Behaviour:
- Reset (asynchronous, rstn=0): state IDLE; all outputs 0; internal counters, pack register and latched config cleared. Release takes effect on the next clock edge.
- State machine: IDLE -> LOAD -> FLUSH -> RUN -> IDLE.
- IDLE:
  - s_ready=0.
  - i_start=1: latch cfg (7 clamped to 6) into o_point_config, clear lane_cnt (2b) and word_cnt (8b), set o_sram_sel=1, go to LOAD.
- LOAD:
  - s_ready=1 every cycle; no back-pressure is ever applied mid-frame.
  - A sample transfers when s_valid && s_ready.
  - Each transfer writes the sample into lane lane_cnt of the pack register, then increments lane_cnt.
  - On the transfer with lane_cnt==3, the full word and word_cnt are registered onto o_wdata/o_waddress with o_write_enable=1 in the next cycle, and word_cnt increments.
  - Write latency: 1 cycle after the 4th sample of a word.
  - The transfer completing word (N/4)-1 deasserts s_ready from the next cycle and moves to FLUSH.
- FLUSH: one cycle in which the final write strobe is issued. Then o_sram_sel=0 and o_working=1 from the next cycle; go to RUN.
- RUN:
  - s_ready=0; o_working held 1.
  - On a cycle where i_fft_done=1: the next cycle gives o_working=0, o_done=1 for exactly one cycle, o_busy=0, state IDLE.
  - If i_fft_done is already high on the first RUN cycle, it is honoured immediately; no minimum run length.
- Address range: words 0..(4<<cfg)-1. cfg 6 uses addresses 0..255 with no wrap; word_cnt never exceeds the frame size.
- i_start outside IDLE is ignored. i_start coincident with o_done is ignored; a new start must arrive while in IDLE.
- i_point_config changes after the latch have no effect until the next i_start.
- s_valid gaps in LOAD: lane and word counters simply hold; there is no timeout.
- o_write_enable never asserts when o_sram_sel=0.
- Reset mid-LOAD or mid-RUN: immediate return to IDLE with all outputs 0. Partially written SRAM contents are undefined and no o_done is produced.

Test Plan:
- Basic load: reset, cfg=0, i_start, 16 back-to-back samples with s_data=n -> 4 writes at addresses 0..3; address 1 carries o_wdata=0x00000007_00000006_00000005_00000004; o_working rises 2 cycles after the last sample.
- Bubbles: cfg=0 with s_valid toggling every other cycle -> identical write data and addresses as the basic load, exactly 4 write strobes, s_ready stays 1 during LOAD.
- Max frame: cfg=6, 1024 samples -> 256 writes at addresses 0..255 in order, no wrap. cfg=7 gives the same result and o_point_config=6.
- Run handshake: hold i_fft_done=0 for 50 cycles, then pulse it -> o_working stays high 50 cycles, drops the cycle after the pulse, o_done high for exactly 1 cycle, o_busy=0 afterwards.
- Ignored controls: i_start pulsed mid-LOAD, and i_point_config changed mid-LOAD -> no restart, frame size unchanged, write count unchanged.
- Reset mid-frame: rstn low after 6 of 16 samples -> all outputs 0 asynchronously. A subsequent i_start with 16 samples completes normally with writes 0..3.
